instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the immediate sign extender.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ready handshake.
- Presents each instruction to decode/sign-extend with a valid/ack handshake.
- Consumes the 64-bit sign-extended branch offset returned for the issued instruction to compute the next PC: sequential, taken conditional, or unconditional.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 29 ++
 rtl/instr_fetch_unit.sv | 93 +++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam logic [63:0] PC_INC   = 64'd4;
    localparam int unsigned BR_SHIFT = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_e;

    // Unconditional branch dominates; Zero only matters for a conditional branch.
    function automatic logic branch_taken(input logic branch, input logic uncond,
                                          input logic zero);
        return uncond | (branch & zero);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential step or PC-relative branch target, modulo 2^PC_W.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = 64
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [63:0]     offset_i,
    input  logic            branch_i,
    input  logic            uncond_i,
    input  logic            zero_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] offset_bytes;
    logic            taken;

    always_comb begin
        // Offset is in words; the top bits shifted out are intentionally dropped.
        offset_bytes = offset_i[PC_W-1:0] << BR_SHIFT;
        taken        = branch_taken(branch_i, uncond_i, zero_i);
        if (taken) begin
            next_pc_o = pc_i + offset_bytes;
        end else begin
            next_pc_o = pc_i + PC_W'(PC_INC);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over req/ready, issues over valid/ack.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W     = 64,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic               CLK,
    input  logic               Reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ack,
    output logic [PC_W-1:0]    pc_out,
    input  logic [63:0]        SignExtImm64,
    input  logic               Branch,
    input  logic               Uncondbranch,
    input  logic               Zero
);

    localparam logic [PC_W-1:0] RESET_PC_ALIGNED = RESET_PC[PC_W-1:0] & ~PC_W'(3);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    next_pc;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc_calc (
        .pc_i      (pc_out_q),
        .offset_i  (SignExtImm64),
        .branch_i  (Branch),
        .uncond_i  (Uncondbranch),
        .zero_i    (Zero),
        .next_pc_o (next_pc)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Branch inputs are only meaningful in the ack cycle.
                if (instr_ack) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC_ALIGNED;
            pc_out_q <= RESET_PC_ALIGNED;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    // Handshake outputs decode straight from the state register so reset drops them at once.
    assign imem_req    = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_ISSUE);
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level PC model.
module tb_instr_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic [63:0] pc_out;
    logic [63:0] SignExtImm64 = '0;
    logic        Branch = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic        Zero = 1'b0;

    int          n_total = 0;
    int          n_bad = 0;
    logic [63:0] exp_pc;

    instr_fetch_unit #(
        .PC_W     (64),
        .RESET_PC (RST_PC)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .instr_ack    (instr_ack),
        .pc_out       (pc_out),
        .SignExtImm64 (SignExtImm64),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .Zero         (Zero)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Branch-side inputs that must not matter outside the ack cycle.
    task automatic noise();
        Branch       = 1'($urandom);
        Uncondbranch = 1'($urandom);
        Zero         = 1'($urandom);
        SignExtImm64 = {$urandom, $urandom};
    endtask

    // Called at a negedge with the DUT fetching from exp_pc; returns at the next fetch.
    task automatic do_instr(input int wait_c, input int hold_c, input logic br, input logic ub,
                            input logic z, input logic [63:0] imm);
        logic [31:0] word;
        logic        taken;
        word = $urandom;
        check_eq("fetch_req", imem_req, 1);
        check_eq("fetch_addr", imem_addr, exp_pc);
        check_eq("fetch_nvalid", instr_valid, 0);
        for (int i = 0; i < wait_c; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            instr_ack  = 1'($urandom);
            noise();
            @(negedge CLK);
            check_eq("wait_req", imem_req, 1);
            check_eq("wait_addr", imem_addr, exp_pc);
            check_eq("wait_nvalid", instr_valid, 0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        instr_ack  = 1'($urandom);
        noise();
        @(negedge CLK);
        check_eq("issue_valid", instr_valid, 1);
        check_eq("issue_nreq", imem_req, 0);
        check_eq("issue_instr", {32'h0, instr_out}, {32'h0, word});
        check_eq("issue_pc", pc_out, exp_pc);
        for (int i = 0; i < hold_c; i++) begin
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            instr_ack  = 1'b0;
            noise();
            @(negedge CLK);
            check_eq("hold_valid", instr_valid, 1);
            check_eq("hold_instr", {32'h0, instr_out}, {32'h0, word});
            check_eq("hold_pc", pc_out, exp_pc);
        end
        imem_ready   = 1'($urandom);
        imem_rdata   = $urandom;
        instr_ack    = 1'b1;
        Branch       = br;
        Uncondbranch = ub;
        Zero         = z;
        SignExtImm64 = imm;
        taken = ub || (br && z);
        @(negedge CLK);
        instr_ack  = 1'b0;
        imem_ready = 1'b0;
        noise();
        exp_pc = taken ? exp_pc + (imm * 64'd4) : exp_pc + 64'd4;
    endtask

    task automatic jump_to(input logic [63:0] target);
        logic signed [63:0] delta;
        delta = $signed(target - exp_pc);
        do_instr(0, 0, 1'b0, 1'b1, 1'b0, 64'(delta >>> 2));
    endtask

    // Reset is already asserted (async) with a memory response pending.
    task automatic reset_tail();
        #1;
        check_eq("rst_async_req", imem_req, 0);
        check_eq("rst_async_valid", instr_valid, 0);
        @(negedge CLK);
        @(negedge CLK);
        check_eq("rst_instr", {32'h0, instr_out}, 64'h0);
        check_eq("rst_pc_out", pc_out, RST_PC);
        Reset = 1'b0;
        @(negedge CLK);
        check_eq("rst_resume_req", imem_req, 1);
        check_eq("rst_resume_addr", imem_addr, RST_PC);
        check_eq("rst_late_ready", instr_valid, 0);
        check_eq("rst_late_instr", {32'h0, instr_out}, 64'h0);
        imem_ready = 1'b0;
        @(negedge CLK);
        check_eq("rst_nodup_valid", instr_valid, 0);
        exp_pc = RST_PC;
    endtask

    initial begin
        #1 Reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("reset_req", imem_req, 0);
        check_eq("reset_valid", instr_valid, 0);
        check_eq("reset_instr", {32'h0, instr_out}, 64'h0);
        check_eq("reset_pc_out", pc_out, RST_PC);
        check_eq("reset_addr", imem_addr, RST_PC);
        Reset = 1'b0;
        @(negedge CLK);
        exp_pc = RST_PC;

        do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0);
        check_eq("seq_step", imem_addr, 64'h1004);
        do_instr(3, 2, 1'b0, 1'b0, 1'b1, 64'h0);
        jump_to(64'h2000);
        do_instr(0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("uncond_neg", imem_addr, 64'h1FF8);
        jump_to(64'h2000);
        do_instr(1, 0, 1'b1, 1'b0, 1'b0, 64'h10);
        check_eq("cbz_not_taken", imem_addr, 64'h2004);
        jump_to(64'h2000);
        do_instr(0, 1, 1'b1, 1'b0, 1'b1, 64'h10);
        check_eq("cbz_taken", imem_addr, 64'h2040);
        jump_to(64'hFFFF_FFFF_FFFF_FFFC);
        do_instr(1, 0, 1'b0, 1'b0, 1'b0, 64'h0);
        check_eq("wrap", imem_addr, 64'h0);

        // Reset during fetch with ready pending.
        imem_ready = 1'b1;
        imem_rdata = 32'h8B02_0020;
        Reset = 1'b1;
        reset_tail();
        do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0);

        // Reset during issue.
        imem_ready = 1'b1;
        imem_rdata = $urandom | 32'h1;
        @(negedge CLK);
        check_eq("pre_rst_valid", instr_valid, 1);
        Reset = 1'b1;
        reset_tail();

        for (int n = 0; n < 150; n++) begin
            logic [63:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                              : 64'($signed($urandom_range(0, 64)) - 32);
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                     ($urandom_range(0, 3) == 0), 1'($urandom), imm);
        end
        check_eq("final_addr", imem_addr, exp_pc);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
